// File: rtl/av_bus_master.sv
// rtl/av_bus_master.sv - single-outstanding Avalon-MM master for core fetch/load/store traffic
module av_bus_master #(
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_Req_Valid,
  output logic        o_Req_Ready,
  input  logic [31:0] i_Req_Addr,
  input  logic        i_Req_Write,
  input  logic [31:0] i_Req_WriteData,
  input  logic [3:0]  i_Req_ByteEn,
  output logic        o_Rsp_Valid,
  output logic [31:0] o_Rsp_ReadData,
  output logic        o_Rsp_Error,
  output logic [31:0] o_AV_Address,
  output logic        o_AV_Read,
  output logic        o_AV_Write,
  output logic [31:0] o_AV_WriteData,
  output logic [3:0]  o_AV_ByteEnable,
  input  logic [31:0] i_AV_ReadData,
  input  logic        i_AV_WaitRequest
);

  // The stall counter only ever needs to reach TIMEOUT_CYCLES-1.
  localparam int          TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  LAT_INIT = 3'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DATA = 2'd2,
    RESP      = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic [31:0]   r_addr;
  logic          r_write;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;
  logic [TW-1:0] r_tmo_cnt;
  logic [2:0]    r_lat_cnt;
  logic [31:0]   r_rdata;
  logic          r_err;

  logic          w_accept;
  logic          w_timeout;
  logic          w_capture;

  assign w_accept  = (r_state == REQ) && !i_AV_WaitRequest;
  assign w_timeout = TMO_EN && (r_state == REQ) && i_AV_WaitRequest && (r_tmo_cnt == TMO_LAST);
  assign w_capture = (r_state == WAIT_DATA) && (r_lat_cnt == 3'd0);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_Req_Valid) begin
          w_next = REQ;
        end
      end
      REQ: begin
        if (w_accept) begin
          w_next = r_write ? RESP : WAIT_DATA;
        end else if (w_timeout) begin
          w_next = RESP;
        end
      end
      WAIT_DATA: begin
        if (w_capture) begin
          w_next = RESP;
        end
      end
      RESP: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_addr    <= '0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_tmo_cnt <= '0;
      r_lat_cnt <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_Req_Valid) begin
            r_addr    <= i_Req_Addr;
            r_write   <= i_Req_Write;
            r_wdata   <= i_Req_WriteData;
            r_be      <= i_Req_ByteEn;
            r_tmo_cnt <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
          end
        end
        REQ: begin
          if (w_accept) begin
            r_lat_cnt <= LAT_INIT;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
          end
        end
        WAIT_DATA: begin
          // Slave data is only trusted on the capture edge itself.
          if (w_capture) begin
            r_rdata <= i_AV_ReadData;
          end else begin
            r_lat_cnt <= r_lat_cnt - 3'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    o_Req_Ready     = 1'b0;
    o_Rsp_Valid     = 1'b0;
    o_Rsp_ReadData  = '0;
    o_Rsp_Error     = 1'b0;
    o_AV_Address    = '0;
    o_AV_Read       = 1'b0;
    o_AV_Write      = 1'b0;
    o_AV_WriteData  = '0;
    o_AV_ByteEnable = '0;
    case (r_state)
      IDLE: begin
        o_Req_Ready = !i_Reset;
      end
      REQ: begin
        o_AV_Address    = r_addr;
        o_AV_Read       = !r_write;
        o_AV_Write      = r_write;
        o_AV_WriteData  = r_write ? r_wdata : 32'd0;
        o_AV_ByteEnable = r_write ? r_be : 4'hF;
      end
      RESP: begin
        o_Rsp_Valid    = 1'b1;
        o_Rsp_ReadData = r_rdata;
        o_Rsp_Error    = r_err;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_av_bus_master.sv
// tb/tb_av_bus_master.sv - directed bench for av_bus_master (latency 1 with timeout 8, latency 3)
module tb_av_bus_master;

  logic        clk = 1'b0;
  logic        rst;

  logic        a_valid, a_ready, a_write, a_rsp_valid, a_rsp_err;
  logic [31:0] a_addr, a_wdata, a_rsp_data;
  logic [3:0]  a_be;
  logic [31:0] a_av_addr, a_av_wdata, a_av_rdata;
  logic        a_av_read, a_av_write, a_av_wait;
  logic [3:0]  a_av_be;

  logic        b_valid, b_ready, b_write, b_rsp_valid, b_rsp_err;
  logic [31:0] b_addr, b_wdata, b_rsp_data;
  logic [3:0]  b_be;
  logic [31:0] b_av_addr, b_av_wdata, b_av_rdata;
  logic        b_av_read, b_av_write, b_av_wait;
  logic [3:0]  b_av_be;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  av_bus_master #(.READ_LATENCY(1), .TIMEOUT_CYCLES(8)) dut_a (
    .i_Clk(clk), .i_Reset(rst),
    .i_Req_Valid(a_valid), .o_Req_Ready(a_ready), .i_Req_Addr(a_addr),
    .i_Req_Write(a_write), .i_Req_WriteData(a_wdata), .i_Req_ByteEn(a_be),
    .o_Rsp_Valid(a_rsp_valid), .o_Rsp_ReadData(a_rsp_data), .o_Rsp_Error(a_rsp_err),
    .o_AV_Address(a_av_addr), .o_AV_Read(a_av_read), .o_AV_Write(a_av_write),
    .o_AV_WriteData(a_av_wdata), .o_AV_ByteEnable(a_av_be),
    .i_AV_ReadData(a_av_rdata), .i_AV_WaitRequest(a_av_wait)
  );

  av_bus_master #(.READ_LATENCY(3), .TIMEOUT_CYCLES(255)) dut_b (
    .i_Clk(clk), .i_Reset(rst),
    .i_Req_Valid(b_valid), .o_Req_Ready(b_ready), .i_Req_Addr(b_addr),
    .i_Req_Write(b_write), .i_Req_WriteData(b_wdata), .i_Req_ByteEn(b_be),
    .o_Rsp_Valid(b_rsp_valid), .o_Rsp_ReadData(b_rsp_data), .o_Rsp_Error(b_rsp_err),
    .o_AV_Address(b_av_addr), .o_AV_Read(b_av_read), .o_AV_Write(b_av_write),
    .o_AV_WriteData(b_av_wdata), .o_AV_ByteEnable(b_av_be),
    .i_AV_ReadData(b_av_rdata), .i_AV_WaitRequest(b_av_wait)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 0; a_addr = 0; a_write = 0; a_wdata = 0; a_be = 0; a_av_rdata = 0; a_av_wait = 0;
    b_valid = 0; b_addr = 0; b_write = 0; b_wdata = 0; b_be = 0; b_av_rdata = 0; b_av_wait = 0;

    tick(); tick();
    chk("rst_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    chk("rst_av_read", {31'd0, a_av_read}, 32'd0);
    chk("rst_av_addr", a_av_addr, 32'd0);
    rst = 1'b0; #1;
    chk("rel_ready", {31'd0, a_ready}, 32'd1);

    // zero-wait read, latency 1
    a_valid = 1; a_addr = 32'h0000_0010; a_write = 0;
    tick();
    chk("rd_av_read", {31'd0, a_av_read}, 32'd1);
    chk("rd_av_write", {31'd0, a_av_write}, 32'd0);
    chk("rd_av_addr", a_av_addr, 32'h0000_0010);
    chk("rd_av_be", {28'd0, a_av_be}, 32'hF);
    chk("rd_ready_req", {31'd0, a_ready}, 32'd0);
    a_valid = 0;
    tick();
    chk("rd_av_read_off", {31'd0, a_av_read}, 32'd0);
    chk("rd_no_rsp_yet", {31'd0, a_rsp_valid}, 32'd0);
    a_av_rdata = 32'h0003_2403;
    tick();
    a_av_rdata = 32'd0;
    chk("rd_rsp_valid", {31'd0, a_rsp_valid}, 32'd1);
    chk("rd_rsp_data", a_rsp_data, 32'h0003_2403);
    chk("rd_rsp_err", {31'd0, a_rsp_err}, 32'd0);
    chk("rd_ready_resp", {31'd0, a_ready}, 32'd0);
    tick();
    chk("rd_rsp_once", {31'd0, a_rsp_valid}, 32'd0);
    chk("rd_rsp_data_idle", a_rsp_data, 32'd0);
    chk("rd_ready_idle", {31'd0, a_ready}, 32'd1);

    // write with three stalled cycles
    a_valid = 1; a_addr = 32'h3000_0004; a_write = 1; a_wdata = 32'h0000_0001; a_be = 4'b0001;
    tick();
    a_valid = 0; a_wdata = 32'hFFFF_FFFF; a_be = 4'hF; a_addr = 32'h0;
    a_av_wait = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) a_av_wait = 0;
      chk("wr_av_write", {31'd0, a_av_write}, 32'd1);
      chk("wr_av_read", {31'd0, a_av_read}, 32'd0);
      chk("wr_av_addr", a_av_addr, 32'h3000_0004);
      chk("wr_av_wdata", a_av_wdata, 32'h0000_0001);
      chk("wr_av_be", {28'd0, a_av_be}, 32'h1);
      chk("wr_rsp_early", {31'd0, a_rsp_valid}, 32'd0);
      tick();
    end
    chk("wr_av_write_off", {31'd0, a_av_write}, 32'd0);
    chk("wr_rsp_valid", {31'd0, a_rsp_valid}, 32'd1);
    chk("wr_rsp_data", a_rsp_data, 32'd0);
    chk("wr_rsp_err", {31'd0, a_rsp_err}, 32'd0);
    tick();
    chk("wr_rsp_once", {31'd0, a_rsp_valid}, 32'd0);

    // timeout with waitrequest stuck high
    a_valid = 1; a_addr = 32'h0000_0040; a_write = 0;
    tick();
    a_valid = 0; a_av_wait = 1; a_av_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 8; i++) begin
      chk("to_av_read_held", {31'd0, a_av_read}, 32'd1);
      chk("to_rsp_early", {31'd0, a_rsp_valid}, 32'd0);
      tick();
    end
    chk("to_av_read_off", {31'd0, a_av_read}, 32'd0);
    chk("to_rsp_valid", {31'd0, a_rsp_valid}, 32'd1);
    chk("to_rsp_err", {31'd0, a_rsp_err}, 32'd1);
    chk("to_rsp_data", a_rsp_data, 32'd0);
    a_av_wait = 0; a_av_rdata = 32'd0;
    tick();
    chk("to_ready_after", {31'd0, a_ready}, 32'd1);
    a_valid = 1; a_addr = 32'h0000_0044;
    tick();
    a_valid = 0;
    chk("to_next_av_read", {31'd0, a_av_read}, 32'd1);
    chk("to_next_av_addr", a_av_addr, 32'h0000_0044);
    tick();
    a_av_rdata = 32'hA5A5_5A5A;
    tick();
    a_av_rdata = 32'd0;
    chk("to_next_rsp_valid", {31'd0, a_rsp_valid}, 32'd1);
    chk("to_next_rsp_data", a_rsp_data, 32'hA5A5_5A5A);
    chk("to_next_rsp_err", {31'd0, a_rsp_err}, 32'd0);
    tick();

    // reset during WAIT_DATA
    a_valid = 1; a_addr = 32'h0000_0080;
    tick();
    a_valid = 0;
    tick();
    rst = 1; a_av_rdata = 32'h0000_1234;
    tick();
    chk("rs_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    chk("rs_rsp_data", a_rsp_data, 32'd0);
    chk("rs_ready", {31'd0, a_ready}, 32'd0);
    chk("rs_av_read", {31'd0, a_av_read}, 32'd0);
    rst = 0; a_av_rdata = 32'd0; #1;
    chk("rs_ready_rel", {31'd0, a_ready}, 32'd1);
    tick();
    chk("rs_no_rsp", {31'd0, a_rsp_valid}, 32'd0);

    // back-to-back with valid held high
    a_valid = 1; a_addr = 32'h0000_0050; a_write = 0; a_av_rdata = 32'h0000_0011;
    tick();
    chk("bb_req_ready", {31'd0, a_ready}, 32'd0);
    chk("bb_req_read", {31'd0, a_av_read}, 32'd1);
    tick();
    chk("bb_wait_ready", {31'd0, a_ready}, 32'd0);
    chk("bb_wait_read", {31'd0, a_av_read}, 32'd0);
    tick();
    chk("bb_resp_ready", {31'd0, a_ready}, 32'd0);
    chk("bb_resp_valid", {31'd0, a_rsp_valid}, 32'd1);
    chk("bb_resp_data", a_rsp_data, 32'h0000_0011);
    tick();
    chk("bb_idle_ready", {31'd0, a_ready}, 32'd1);
    chk("bb_idle_read", {31'd0, a_av_read}, 32'd0);
    tick();
    chk("bb_second_read", {31'd0, a_av_read}, 32'd1);
    chk("bb_second_ready", {31'd0, a_ready}, 32'd0);
    a_valid = 0;
    tick(); tick();
    chk("bb_second_rsp", {31'd0, a_rsp_valid}, 32'd1);
    a_av_rdata = 32'd0;
    tick();

    // latency-3 read: data present only on the capture edge
    b_valid = 1; b_addr = 32'h0000_0020; b_write = 0;
    tick();
    b_valid = 0;
    chk("l3_av_read", {31'd0, b_av_read}, 32'd1);
    tick();
    chk("l3_av_read_off", {31'd0, b_av_read}, 32'd0);
    tick();
    chk("l3_no_rsp_e2", {31'd0, b_rsp_valid}, 32'd0);
    tick();
    chk("l3_no_rsp_e3", {31'd0, b_rsp_valid}, 32'd0);
    b_av_rdata = 32'hDEAD_BEEF;
    tick();
    b_av_rdata = 32'd0;
    chk("l3_rsp_valid", {31'd0, b_rsp_valid}, 32'd1);
    chk("l3_rsp_data", b_rsp_data, 32'hDEAD_BEEF);
    tick();
    chk("l3_rsp_once", {31'd0, b_rsp_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/av_bus_master.md
Name: av_bus_master

Overview:
- Avalon-MM single-outstanding master bridging a simple core-side request/response port onto the SOC Avalon interconnect.
- Fetch and load/store units use it to reach the ROM, RAM and peripheral slaves.
- Issues one read or write at a time, honours WaitRequest, captures read data a fixed READ_LATENCY after command acceptance, and returns a one-cycle response.
- Aborts with an error response if WaitRequest is held too long.

Parameters:
- READ_LATENCY, 1: cycles from the command-accept edge to the edge where read data is sampled. Legal range 1..7. The ROM and RAM slaves use 1.
- TIMEOUT_CYCLES, 255: maximum cycles a command may remain stalled by WaitRequest before it is aborted. 0 disables the timeout.

Ports:
- i_Clk  in  1  system clock
- i_Reset  in  1  synchronous, active-high reset
- i_Req_Valid  in  1  core request present
- o_Req_Ready  out  1  master can accept a request this cycle
- i_Req_Addr  in  32  byte address. Bits [1:0] are passed through unmodified.
- i_Req_Write  in  1  1 = write, 0 = read
- i_Req_WriteData  in  32  write data
- i_Req_ByteEn  in  4  write byte enables
- o_Rsp_Valid  out  1  one-cycle response pulse. No backpressure.
- o_Rsp_ReadData  out  32  read data. 0 for writes and for errors.
- o_Rsp_Error  out  1  timeout abort; qualified by o_Rsp_Valid
- o_AV_Address  out  32  Avalon address
- o_AV_Read  out  1  Avalon read command
- o_AV_Write  out  1  Avalon write command
- o_AV_WriteData  out  32  Avalon write data
- o_AV_ByteEnable  out  4  Avalon byte enables. Driven 4'hF on reads.
- i_AV_ReadData  in  32  Avalon read data
- i_AV_WaitRequest  in  1  slave stall

Behaviour:
- Clocking and reset:
  - One clock, i_Clk. Reset is synchronous and active-high on i_Reset.
  - Reset forces state IDLE. All outputs go to 0 (o_Req_Ready=0 during reset), except o_Req_Ready=1 in the first cycle after reset release.
  - Reset mid-transaction drops the transaction: commands deassert on the next edge and no response is produced.
- FSM states: IDLE, REQ, WAIT_DATA, RESP.
- IDLE:
  - o_Req_Ready=1. All AV command outputs are 0.
  - If i_Req_Valid=1 at the edge: register addr, write flag, data and byte enables; clear the timeout counter; go to REQ.
- REQ:
  - o_AV_Read or o_AV_Write=1 (exactly one) with the registered address/data. These hold stable while i_AV_WaitRequest=1.
  - At an edge with i_AV_WaitRequest=0 the command is accepted:
    - write: go to RESP.
    - read: go to WAIT_DATA with latency counter = READ_LATENCY-1.
  - Commands deassert in the cycle after acceptance.
  - At an edge with i_AV_WaitRequest=1: increment the timeout counter. If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1, abort: go to RESP with error=1 and read data=0.
- WAIT_DATA:
  - No command is driven.
  - Counter at 0: sample i_AV_ReadData at that edge, go to RESP. Otherwise decrement.
  - i_AV_ReadData is sampled only at the capture edge. Slaves drive 0 when idle.
- RESP:
  - o_Rsp_Valid=1 for exactly one cycle, with o_Rsp_ReadData and o_Rsp_Error. o_Req_Ready=0.
  - Next state IDLE. Response outputs return to 0 in IDLE.
- Latency:
  - Zero-wait read: request edge e0, accept edge e1, capture edge e1+READ_LATENCY, o_Rsp_Valid in the following cycle.
  - Zero-wait write: o_Rsp_Valid in the cycle after e1.
- WaitRequest is ignored outside REQ. A request arriving while not in IDLE is not accepted; the core holds it.

Test Plan:
- Zero-wait read, READ_LATENCY=1. Request addr 0x0000_0010; slave returns 0x00032403 one cycle after accept -> o_AV_Read high exactly 1 cycle; o_Rsp_Valid 1 cycle with data 0x00032403, error 0; total 3 edges from request to response cycle.
- Write with 3 WaitRequest cycles. Addr 0x3000_0004, data 0x0000_0001, ByteEn 4'b0001 -> o_AV_Write held 4 cycles with stable addr/data/ByteEn; one o_Rsp_Valid, ReadData 0, error 0.
- READ_LATENCY=3 read with slave data 0xDEADBEEF valid only on the 3rd edge after accept (0 otherwise) -> response data exactly 0xDEADBEEF.
- Timeout, TIMEOUT_CYCLES=8, WaitRequest stuck high -> command deasserts after 8 stalled cycles; o_Rsp_Valid with error 1 and data 0; next request accepted normally.
- Reset asserted during WAIT_DATA -> no o_Rsp_Valid; all outputs 0 next cycle; o_Req_Ready=1 after release.
- Back-to-back requests with i_Req_Valid held high -> second request accepted only in the IDLE cycle after RESP; o_Req_Ready never high during REQ/WAIT_DATA/RESP.
